// File: rtl/alu_share_ctrl.sv
// Round-robin front end for one shared combinational ALU: accepts a request from one of two
// requesters, holds its operands on the ALU bus for SETTLE cycles, then returns result and flags.
module alu_share_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    output logic [3:0]       alu_op,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    input  logic [N-1:0]     alu_res,
    input  logic [3:0]       alu_flags,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [N-1:0]     rsp_res,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    logic [1:0]       r_state;
    logic             r_gnt;
    logic [3:0]       r_cnt;
    logic [3:0]       r_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_res;
    logic [3:0]       r_flags;
    logic             r_err;
    logic [CNT_W-1:0] r_done_cnt;

    logic w_accept;
    logic w_gnt;
    logic w_illegal;
    logic w_taken;

    // On contention the requester not served last wins; r_gnt doubles as the "last granted" pointer.
    assign w_gnt     = (req_valid[0] && req_valid[1]) ? ~r_gnt : req_valid[1];
    assign w_accept  = rst_n && (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_illegal = (r_op > 4'h9);
    assign w_taken   = rsp_ready[r_gnt];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b1;
            r_cnt      <= 4'd0;
            r_op       <= 4'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_flags    <= 4'd0;
            r_err      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_gnt;
                        r_op    <= w_gnt ? req_op1 : req_op0;
                        r_a     <= w_gnt ? req_a1 : req_a0;
                        r_b     <= w_gnt ? req_b1 : req_b0;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Illegal opcodes return a clean zero result rather than whatever the ALU shows.
                        r_res   <= w_illegal ? '0 : alu_res;
                        r_flags <= w_illegal ? 4'd0 : alu_flags;
                        r_err   <= w_illegal;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_taken) begin
                        r_done_cnt <= r_done_cnt + CNT_W'(1);
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (r_state == S_RESP) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_res   = r_res;
    assign rsp_flags = r_flags;
    assign rsp_err   = r_err;
    assign busy      = (r_state != S_IDLE);
    assign done_cnt  = r_done_cnt;

endmodule
